// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze map constants, row type and cell helper
package maze_pkg;

    localparam int COLS       = 64;
    localparam int ROWS       = 48;
    localparam int NUM_LEVELS = 4;
    localparam int LVL_W      = 3;
    localparam int LVL_TITLE  = 0;
    localparam int LVL_END    = 7;

    localparam logic [63:0] L1_ROW0 = 64'hFFFF_FFFF_FFFF_FB87;

    typedef logic [COLS-1:0] row_t;

    function automatic logic border_cell(input int r, input int c, input int rows, input int cols);
        return (r == 0) || (r == rows - 1) || (c == 0) || (c == cols - 1);
    endfunction

endpackage

// File: rtl/maze_level_rom.sv
// rtl/maze_level_rom.sv - combinational level/screen bitmap ROM, (idx, row) -> row bits
module maze_level_rom #(
    parameter int COLS       = maze_pkg::COLS,
    parameter int ROWS       = maze_pkg::ROWS,
    parameter int NUM_LEVELS = maze_pkg::NUM_LEVELS,
    parameter int LVL_W      = maze_pkg::LVL_W,
    parameter int ROW_W      = $clog2(ROWS),
    parameter int COL_W      = $clog2(COLS)
) (
    input  logic [LVL_W-1:0] idx,
    input  logic [ROW_W-1:0] row,
    output logic [COLS-1:0]  row_data
);
    import maze_pkg::*;

    int   r_i;
    int   lvl_i;
    logic b;
    logic w;

    // Bitmaps are generated from per-cell rules so they scale with COLS/ROWS.
    always_comb begin
        row_data = '0;
        r_i      = int'(row);
        lvl_i    = int'(idx);
        b        = 1'b0;
        w        = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            b = border_cell(r_i, c, ROWS, COLS);
            w = 1'b0;
            if (lvl_i == LVL_END) begin
                w = b || ((r_i % 2 == 0) && (c % 2 == 0));
            end else if (lvl_i == LVL_TITLE) begin
                w = b || ((r_i == ROWS / 2) && (c >= 8) && (c < COLS - 8));
            end else if (lvl_i <= NUM_LEVELS) begin
                case (lvl_i)
                    1: w = (r_i == 0) ? L1_ROW0[6'(c % 64)]
                         : (b || ((r_i % 4 == 0) && (c % 8 != 3)) || ((r_i % 4 == 2) && (c % 8 == 0)));
                    2: w = b || ((r_i % 6 == 3) && (c % 10 < 7));
                    3: w = b || ((c % 6 == 3) && (r_i % 5 != 1));
                    default: w = b || ((r_i + c) % 7 == 0);
                endcase
            end
            row_data[COL_W'(c)] = w;
        end
    end

endmodule

// File: rtl/maze_map_store.sv
// rtl/maze_map_store.sv - sequentially loaded maze map with cell queries and row reads; option MAP_EDIT_EN
module maze_map_store #(
    parameter int COLS       = maze_pkg::COLS,
    parameter int ROWS       = maze_pkg::ROWS,
    parameter int NUM_LEVELS = maze_pkg::NUM_LEVELS,
    parameter int LVL_W      = maze_pkg::LVL_W,
    parameter int ROW_W      = $clog2(ROWS),
    parameter int COL_W      = $clog2(COLS)
) (
    input  logic             Clk,
    input  logic             Reset,
`ifdef MAP_EDIT_EN
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COL_W-1:0] wr_col,
    input  logic             wr_val,
`endif
    input  logic [LVL_W-1:0] level_sel,
    input  logic             end_screen,
    input  logic             load_start,
    output logic             busy,
    output logic             load_done,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [ROW_W-1:0] q_row,
    input  logic [COL_W-1:0] q_col,
    output logic             q_rsp_valid,
    output logic             q_wall,
    input  logic [ROW_W-1:0] rd_row,
    output logic [COLS-1:0]  rd_data
);
    import maze_pkg::*;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t           state_q, state_d;
    logic [LVL_W-1:0] idx_q, idx_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic [COLS-1:0]  map_q [ROWS];
    logic [COLS-1:0]  map_d [ROWS];
    logic             busy_q, busy_d;
    logic             load_done_q, load_done_d;
    logic             q_rsp_valid_q, q_rsp_valid_d;
    logic             q_wall_q, q_wall_d;
    logic [COLS-1:0]  rd_data_q, rd_data_d;
    logic [COLS-1:0]  rom_row;
    logic             q_accept;

    maze_level_rom #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .NUM_LEVELS (NUM_LEVELS),
        .LVL_W      (LVL_W),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W)
    ) u_rom (
        .idx      (idx_q),
        .row      (row_cnt_q),
        .row_data (rom_row)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        row_cnt_d   = row_cnt_q;
        map_d       = map_q;
        load_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d   = LOAD;
                    idx_d     = end_screen ? LVL_W'(LVL_END) : level_sel;
                    row_cnt_d = '0;
                end
            end
            LOAD: begin
                map_d[row_cnt_q] = rom_row;
                row_cnt_d        = row_cnt_q + 1'b1;
                if (row_cnt_q == ROW_W'(ROWS - 1)) begin
                    state_d     = DONE;
                    load_done_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef MAP_EDIT_EN
        if ((state_q == IDLE) && wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS))
            map_d[wr_row][wr_col] = wr_val;
`endif
        busy_d = (state_d != IDLE);

        // Queries always read the pre-edit map, so a same-cycle write is not seen yet.
        q_accept      = q_valid && !busy_q;
        q_rsp_valid_d = q_accept;
        q_wall_d      = q_wall_q;
        if (q_accept) begin
            if ((int'(q_row) < ROWS) && (int'(q_col) < COLS))
                q_wall_d = map_q[q_row][q_col];
            else
                q_wall_d = 1'b1;
        end

        rd_data_d = (int'(rd_row) < ROWS) ? map_q[rd_row] : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            row_cnt_q     <= '0;
            busy_q        <= 1'b0;
            load_done_q   <= 1'b0;
            q_rsp_valid_q <= 1'b0;
            q_wall_q      <= 1'b0;
            rd_data_q     <= '0;
            for (int r = 0; r < ROWS; r++) map_q[r] <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            row_cnt_q     <= row_cnt_d;
            busy_q        <= busy_d;
            load_done_q   <= load_done_d;
            q_rsp_valid_q <= q_rsp_valid_d;
            q_wall_q      <= q_wall_d;
            rd_data_q     <= rd_data_d;
            map_q         <= map_d;
        end
    end

    assign busy        = busy_q;
    assign load_done   = load_done_q;
    assign q_ready     = !busy_q;
    assign q_rsp_valid = q_rsp_valid_q;
    assign q_wall      = q_wall_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_maze_map_store.sv
// tb/tb_maze_map_store.sv - directed self-checking bench for maze_map_store
module tb_maze_map_store;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [2:0]  level_sel = '0;
    logic        end_screen = 1'b0;
    logic        load_start = 1'b0;
    logic        busy, load_done, q_ready, q_rsp_valid, q_wall;
    logic        q_valid = 1'b0;
    logic [5:0]  q_row = '0;
    logic [5:0]  q_col = '0;
    logic [5:0]  rd_row = '0;
    logic [63:0] rd_data;

    logic        busy2, load_done2, q_ready2, q_rsp_valid2, q_wall2;
    logic        q2_valid = 1'b0;
    logic [4:0]  q2_row = '0;
    logic [5:0]  q2_col = '0;
    logic [39:0] rd_data2;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    maze_map_store dut (
        .Clk         (Clk),
        .Reset       (Reset),
`ifdef MAP_EDIT_EN
        .wr_en       (1'b0),
        .wr_row      (6'd0),
        .wr_col      (6'd0),
        .wr_val      (1'b0),
`endif
        .level_sel   (level_sel),
        .end_screen  (end_screen),
        .load_start  (load_start),
        .busy        (busy),
        .load_done   (load_done),
        .q_valid     (q_valid),
        .q_ready     (q_ready),
        .q_row       (q_row),
        .q_col       (q_col),
        .q_rsp_valid (q_rsp_valid),
        .q_wall      (q_wall),
        .rd_row      (rd_row),
        .rd_data     (rd_data)
    );

    maze_map_store #(.COLS(40), .ROWS(30)) dut2 (
        .Clk         (Clk),
        .Reset       (Reset),
`ifdef MAP_EDIT_EN
        .wr_en       (1'b0),
        .wr_row      (5'd0),
        .wr_col      (6'd0),
        .wr_val      (1'b0),
`endif
        .level_sel   (3'd0),
        .end_screen  (1'b0),
        .load_start  (1'b0),
        .busy        (busy2),
        .load_done   (load_done2),
        .q_valid     (q2_valid),
        .q_ready     (q_ready2),
        .q_row       (q2_row),
        .q_col       (q2_col),
        .q_rsp_valid (q_rsp_valid2),
        .q_wall      (q_wall2),
        .rd_row      (5'd0),
        .rd_data     (rd_data2)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_load(input logic [2:0] lvl, input logic es);
        level_sel  = lvl;
        end_screen = es;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        end_screen = 1'b0;
    endtask

    // Returns the cycle count (load_start cycle = 0) at which load_done is seen, or -1.
    task automatic wait_done(output int n);
        int cnt;
        cnt = 1;
        while (!load_done && cnt < 200) begin
            tick();
            cnt++;
        end
        n = load_done ? cnt : -1;
    endtask

    task automatic read_row(input int r, output logic [63:0] d);
        rd_row = 6'(r);
        tick();
        d = rd_data;
    endtask

    task automatic test_reset();
        tests++;
        if ({busy, load_done, q_rsp_valid, q_wall, q_ready} !== 5'b00001) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 00001", {busy, load_done, q_rsp_valid, q_wall, q_ready});
        end
        tests++;
        if (rd_data !== 64'h0) begin
            fails++;
            $display("FAIL reset_rd_data: got %h expected 0", rd_data);
        end
    endtask

    task automatic test_load_level1();
        int n;
        logic [63:0] d;
        start_load(3'd1, 1'b0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL load1_busy: got %b expected 1", busy);
        end
        wait_done(n);
        tests++;
        if (n != 49) begin
            fails++;
            $display("FAIL load1_done_latency: got %0d expected 49", n);
        end
        tick();
        tests++;
        if ({load_done, busy} !== 2'b00) begin
            fails++;
            $display("FAIL load1_after_done: got %b expected 00", {load_done, busy});
        end
        read_row(0, d);
        tests++;
        if (d !== 64'hFFFF_FFFF_FFFF_FB87) begin
            fails++;
            $display("FAIL load1_row0: got %h expected FFFFFFFFFFFFFB87", d);
        end
        read_row(1, d);
        tests++;
        if (d !== 64'h8000_0000_0000_0001) begin
            fails++;
            $display("FAIL load1_row1: got %h expected 8000000000000001", d);
        end
        read_row(47, d);
        tests++;
        if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            fails++;
            $display("FAIL load1_row47: got %h expected FFFFFFFFFFFFFFFF", d);
        end
        read_row(48, d);
        tests++;
        if (d !== 64'h0) begin
            fails++;
            $display("FAIL load1_row48: got %h expected 0", d);
        end
    endtask

    task automatic test_query();
        q_valid = 1'b1; q_row = 6'd0; q_col = 6'd3;
        tick();
        tests++;
        if ({q_rsp_valid, q_wall} !== 2'b10) begin
            fails++;
            $display("FAIL query_0_3: got %b expected 10", {q_rsp_valid, q_wall});
        end
        q_col = 6'd0;
        tick();
        tests++;
        if ({q_rsp_valid, q_wall} !== 2'b11) begin
            fails++;
            $display("FAIL query_0_0: got %b expected 11", {q_rsp_valid, q_wall});
        end
        q_valid = 1'b0;
        tick();
        tests++;
        if (q_rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL query_idle_rsp: got %b expected 0", q_rsp_valid);
        end
        q_valid = 1'b1; q_row = 6'd1; q_col = 6'd5;
        tick();
        tests++;
        if ({q_rsp_valid, q_wall} !== 2'b10) begin
            fails++;
            $display("FAIL query_1_5: got %b expected 10", {q_rsp_valid, q_wall});
        end
        q_row = 6'd48;
        tick();
        tests++;
        if ({q_rsp_valid, q_wall} !== 2'b11) begin
            fails++;
            $display("FAIL query_row48: got %b expected 11", {q_rsp_valid, q_wall});
        end
        q_valid = 1'b0;
        tick();
    endtask

    task automatic test_query_busy();
        int n;
        start_load(3'd1, 1'b0);
        q_valid = 1'b1; q_row = 6'd0; q_col = 6'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if ({q_ready, q_rsp_valid} !== 2'b00) begin
                fails++;
                $display("FAIL query_busy_%0d: got %b expected 00", i, {q_ready, q_rsp_valid});
            end
        end
        q_valid = 1'b0;
        wait_done(n);
        tick();
    endtask

    task automatic test_end_screen();
        int n;
        logic [63:0] d;
        start_load(3'd2, 1'b1);
        wait_done(n);
        tests++;
        if (n != 49) begin
            fails++;
            $display("FAIL end_done_latency: got %0d expected 49", n);
        end
        read_row(2, d);
        tests++;
        if (d !== 64'hD555_5555_5555_5555) begin
            fails++;
            $display("FAIL end_row2: got %h expected D555555555555555", d);
        end
        read_row(1, d);
        tests++;
        if (d !== 64'h8000_0000_0000_0001) begin
            fails++;
            $display("FAIL end_row1: got %h expected 8000000000000001", d);
        end
    endtask

    task automatic test_blank_level();
        int n;
        logic [63:0] d;
        start_load(3'd6, 1'b0);
        wait_done(n);
        tests++;
        if (n != 49) begin
            fails++;
            $display("FAIL blank_done_latency: got %0d expected 49", n);
        end
        for (int r = 0; r < 48; r++) begin
            read_row(r, d);
            tests++;
            if (d !== 64'h0) begin
                fails++;
                $display("FAIL blank_row%0d: got %h expected 0", r, d);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int cnt;
        int first;
        int pulses;
        logic [63:0] d;
        start_load(3'd1, 1'b0);
        cnt = 1; first = -1; pulses = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            cnt++;
        end
        level_sel = 3'd3; end_screen = 1'b1; load_start = 1'b1;
        tick();
        cnt++;
        load_start = 1'b0; end_screen = 1'b0;
        while (cnt < 160) begin
            if (load_done) begin
                pulses++;
                if (first < 0) first = cnt;
            end
            tick();
            cnt++;
        end
        tests++;
        if (first != 49) begin
            fails++;
            $display("FAIL restart_done_point: got %0d expected 49", first);
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL restart_pulses: got %0d expected 1", pulses);
        end
        read_row(2, d);
        tests++;
        if (d !== 64'h8101_0101_0101_0101) begin
            fails++;
            $display("FAIL restart_row2: got %h expected 8101010101010101", d);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [63:0] d;
        logic seen;
        seen = 1'b0;
        start_load(3'd1, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        Reset = 1'b1;
        #1;
        tests++;
        if ({busy, load_done} !== 2'b00) begin
            fails++;
            $display("FAIL midreset_busy: got %b expected 00", {busy, load_done});
        end
        tick();
        Reset = 1'b0;
        for (int r = 0; r < 48; r++) begin
            read_row(r, d);
            if (load_done) seen = 1'b1;
            tests++;
            if (d !== 64'h0) begin
                fails++;
                $display("FAIL midreset_row%0d: got %h expected 0", r, d);
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (load_done || busy) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL midreset_no_done: got %b expected 0", seen);
        end
    endtask

    task automatic test_param_oob();
        logic [4:0] rows [6];
        logic [5:0] cols [6];
        logic       exp  [6];
        rows = '{5'd5, 5'd5, 5'd30, 5'd31, 5'd5, 5'd29};
        cols = '{6'd40, 6'd63, 6'd0, 6'd63, 6'd5, 6'd39};
        exp  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            q2_valid = 1'b1; q2_row = rows[i]; q2_col = cols[i];
            tick();
            tests++;
            if ({q_rsp_valid2, q_wall2} !== {1'b1, exp[i]}) begin
                fails++;
                $display("FAIL oob_query_%0d_%0d: got %b expected 1%b", rows[i], cols[i], {q_rsp_valid2, q_wall2}, exp[i]);
            end
        end
        q2_valid = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        tick();
        test_reset();
        test_load_level1();
        test_query();
        test_query_busy();
        test_end_screen();
        test_blank_level();
        test_restart_ignored();
        test_reset_mid_load();
        test_param_oob();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
